// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline sequencing controller for the 5-stage MIPS core. It sits beside
//   ID and decides each cycle whether the front end advances, stalls or is
//   flushed. It also issues to the multi-cycle mult/div unit and tracks how
//   long that unit stays busy.
//
// Parameters
//   MULDIV_CYCLES  mult/div latency in cycles (>= 1)
//   CNT_W          busy counter width (2**CNT_W > MULDIV_CYCLES)
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   IdRs/IdRt            source register fields of the ID instruction
//   IdUseRs/IdUseRt      ID instruction actually reads rs / rt
//   IdMulDiv/IdMfHiLo    ID instruction is mult/div, or accesses HI/LO
//   ExDst/ExMem2R/ExRegW destination, is-load and writes-reg of EX instruction
//   ExBranchTaken/ExJump redirect resolved in EX
//   PcWrite/IfIdWrite    PC and IF/ID load enables
//   IfIdFlush/IdExFlush  clear IF/ID, bubble into ID/EX on next edge
//   MdStart              one-cycle start pulse to mult/div unit
//   MdBusy               mult/div unit occupied
module hazard_ctrl #(
    parameter int unsigned MULDIV_CYCLES = 32,
    parameter int unsigned CNT_W         = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] IdRs,
    input  logic [4:0] IdRt,
    input  logic       IdUseRs,
    input  logic       IdUseRt,
    input  logic       IdMulDiv,
    input  logic       IdMfHiLo,
    input  logic [4:0] ExDst,
    input  logic       ExMem2R,
    input  logic       ExRegW,
    input  logic       ExBranchTaken,
    input  logic       ExJump,
    output logic       PcWrite,
    output logic       IfIdWrite,
    output logic       IfIdFlush,
    output logic       IdExFlush,
    output logic       MdStart,
    output logic       MdBusy
);

    typedef enum logic {RUN, MDBUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic redirect;
    logic load_use;
    logic hilo_stall;
    logic issue;

    always_comb begin
        redirect   = ExBranchTaken | ExJump;
        // $0 is hard-wired, so a load targeting it can never create a hazard.
        load_use   = ExMem2R & ExRegW & (ExDst != 5'd0) &
                     ((IdUseRs & (IdRs == ExDst)) | (IdUseRt & (IdRt == ExDst)));
        hilo_stall = (state == MDBUSY) & (IdMulDiv | IdMfHiLo);
        issue      = (state == RUN) & IdMulDiv & ~redirect & ~load_use;
    end

    always_comb begin
        PcWrite   = 1'b1;
        IfIdWrite = 1'b1;
        IfIdFlush = 1'b0;
        IdExFlush = 1'b0;
        MdStart   = 1'b0;
        MdBusy    = (state == MDBUSY);
        if (rst) begin
            PcWrite   = 1'b0;
            IfIdWrite = 1'b0;
            IfIdFlush = 1'b1;
            IdExFlush = 1'b1;
            MdBusy    = 1'b0;
        end else if (redirect) begin
            // Wrong-path ID instruction is killed; overrides every stall.
            IfIdFlush = 1'b1;
            IdExFlush = 1'b1;
        end else if (load_use | hilo_stall) begin
            PcWrite   = 1'b0;
            IfIdWrite = 1'b0;
            IdExFlush = 1'b1;
        end else begin
            MdStart   = issue;
        end
    end

    // A redirect does not touch the counter: the mult/div in flight is older
    // than the branch and must complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (issue) begin
                        state <= MDBUSY;
                        cnt   <= CNT_W'(MULDIV_CYCLES - 1);
                    end
                end
                MDBUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Self-checking bench for hazard_ctrl with MULDIV_CYCLES=4. Each step
//   drives one cycle of inputs, pushes the expected outputs from a small
//   reference model onto a scoreboard queue, and pops/compares at the
//   falling edge.
module tb_hazard_ctrl;

    localparam int unsigned N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] IdRs, IdRt, ExDst;
    logic       IdUseRs, IdUseRt, IdMulDiv, IdMfHiLo;
    logic       ExMem2R, ExRegW, ExBranchTaken, ExJump;
    logic       PcWrite, IfIdWrite, IfIdFlush, IdExFlush, MdStart, MdBusy;
    logic [5:0] outs;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULDIV_CYCLES(N), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .IdRs(IdRs), .IdRt(IdRt), .IdUseRs(IdUseRs), .IdUseRt(IdUseRt),
        .IdMulDiv(IdMulDiv), .IdMfHiLo(IdMfHiLo),
        .ExDst(ExDst), .ExMem2R(ExMem2R), .ExRegW(ExRegW),
        .ExBranchTaken(ExBranchTaken), .ExJump(ExJump),
        .PcWrite(PcWrite), .IfIdWrite(IfIdWrite), .IfIdFlush(IfIdFlush),
        .IdExFlush(IdExFlush), .MdStart(MdStart), .MdBusy(MdBusy)
    );

    assign outs = {PcWrite, IfIdWrite, IfIdFlush, IdExFlush, MdStart, MdBusy};

    // Output vectors {PcWrite,IfIdWrite,IfIdFlush,IdExFlush,MdStart,MdBusy}
    localparam logic [5:0] O_RESET = 6'b001100;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       md;
        logic       mf;
        logic [4:0] dst;
        logic       mem2r;
        logic       regw;
        logic       br;
        logic       jmp;
    } stim_t;

    typedef struct {
        string      tag;
        logic [5:0] exp;
    } exp_t;

    exp_t        sb[$];
    int unsigned starts[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned busy_left = 0;   // model: busy cycles still to come
    logic [5:0]  obs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic logic mdl_lu(input stim_t s);
        return s.mem2r && s.regw && s.dst != 5'd0 &&
               ((s.urs && s.rs == s.dst) || (s.urt && s.rt == s.dst));
    endfunction

    function automatic logic [5:0] mdl_out(input stim_t s);
        logic busy;
        busy = (busy_left > 0);
        if (s.rst)                              return O_RESET;
        if (s.br || s.jmp)                      return {5'b11110, busy};
        if (mdl_lu(s) || (busy && (s.md || s.mf))) return {5'b00010, busy};
        return {4'b1100, (!busy && s.md), busy};
    endfunction

    task automatic mdl_edge(input stim_t s);
        if (s.rst)
            busy_left = 0;
        else if (busy_left == 0 && s.md && !s.br && !s.jmp && !mdl_lu(s))
            busy_left = N;
        else if (busy_left > 0)
            busy_left--;
    endtask

    task automatic step(input stim_t s, input string tag);
        exp_t e;
        rst = s.rst; IdRs = s.rs; IdRt = s.rt; IdUseRs = s.urs; IdUseRt = s.urt;
        IdMulDiv = s.md; IdMfHiLo = s.mf; ExDst = s.dst; ExMem2R = s.mem2r;
        ExRegW = s.regw; ExBranchTaken = s.br; ExJump = s.jmp;
        e.tag = tag;
        e.exp = mdl_out(s);
        sb.push_back(e);
        @(negedge clk);
        obs = outs;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check(e.tag, {26'd0, obs}, {26'd0, e.exp});
        end
        check({tag, "_inv"}, {31'd0, obs[5] & ~obs[4]}, 0);
        if (obs[1]) starts.push_back(cyc);
        @(posedge clk);
        mdl_edge(s);
        cyc++;
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        int unsigned stalls;
        rst = 1'b1; IdRs = '0; IdRt = '0; IdUseRs = 0; IdUseRt = 0; IdMulDiv = 0;
        IdMfHiLo = 0; ExDst = '0; ExMem2R = 0; ExRegW = 0; ExBranchTaken = 0; ExJump = 0;
        @(posedge clk); #1;

        s = idle(); s.rst = 1;
        step(s, "reset0");
        step(s, "reset1");

        // Load-use on rs, then release
        s = idle(); s.dst = 8; s.mem2r = 1; s.regw = 1; s.rs = 8; s.urs = 1;
        step(s, "lu_rs");
        s.mem2r = 0;
        step(s, "lu_release");
        // Load-use on rt
        s = idle(); s.dst = 5; s.mem2r = 1; s.regw = 1; s.rt = 5; s.urt = 1;
        step(s, "lu_rt");
        // $0 never stalls; unused operand never stalls; non-writing load
        s = idle(); s.dst = 0; s.mem2r = 1; s.regw = 1; s.rs = 0; s.urs = 1;
        step(s, "lu_r0");
        s = idle(); s.dst = 9; s.mem2r = 1; s.regw = 1; s.rt = 9; s.urt = 0;
        step(s, "lu_unused_rt");
        s = idle(); s.dst = 9; s.mem2r = 1; s.regw = 0; s.rs = 9; s.urs = 1;
        step(s, "lu_no_regw");

        // Redirect beats load-use; redirect suppresses issue
        s = idle(); s.dst = 8; s.mem2r = 1; s.regw = 1; s.rs = 8; s.urs = 1; s.br = 1;
        step(s, "redir_over_lu");
        s = idle(); s.jmp = 1; s.md = 1;
        step(s, "redir_no_issue");
        s = idle();
        step(s, "after_redir_idle");

        // Issue, then mfhi held until the unit frees
        s = idle(); s.md = 1;
        step(s, "issue1");
        stalls = 0;
        s = idle(); s.mf = 1;
        for (int i = 0; i < 8 && obs[5] == 1'b0 || i == 0; i++) begin
            step(s, "mfhi_wait");
            if (obs[5] == 1'b0) stalls++;
        end
        check("mfhi_stall_cycles", stalls, N);

        // Independent add during busy, plus overlapping load-use + HI/LO stall
        s = idle(); s.md = 1;
        step(s, "issue2");
        s = idle(); s.rs = 3; s.urs = 1;
        step(s, "add_busy");
        s = idle(); s.mf = 1; s.dst = 4; s.mem2r = 1; s.regw = 1; s.rs = 4; s.urs = 1;
        step(s, "lu_and_hilo");
        s = idle();
        for (int i = 0; i < 3; i++) step(s, "drain2");

        // Jump at busy cycle 2, busy still ends on schedule
        s = idle(); s.md = 1;
        step(s, "issue3");
        s = idle();
        step(s, "busy3_c1");
        s.jmp = 1;
        step(s, "busy3_jump");
        s.jmp = 0;
        step(s, "busy3_c3");
        step(s, "busy3_c4");
        step(s, "busy3_done");

        // Reset at busy cycle 2 abandons the operation
        s = idle(); s.md = 1;
        step(s, "issue4");
        s = idle();
        step(s, "busy4_c1");
        s.rst = 1;
        step(s, "busy4_rst");
        s.rst = 0;
        step(s, "after_rst");
        s.md = 1;
        step(s, "issue_after_rst");
        s = idle();
        for (int i = 0; i < N; i++) step(s, "drain5");

        // Back-to-back mult: second issues N+1 cycles after the first
        starts.delete();
        s = idle(); s.md = 1;
        for (int i = 0; i < N + 2; i++) step(s, "b2b");
        check("b2b_starts", starts.size(), 2);
        if (starts.size() >= 2) check("b2b_gap", starts[1] - starts[0], N + 1);
        s = idle();
        for (int i = 0; i < N; i++) step(s, "drain6");

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            s = idle();
            s.rst   = ($urandom_range(0, 60) == 0);
            s.rs    = 5'($urandom_range(0, 3));
            s.rt    = 5'($urandom_range(0, 3));
            s.dst   = 5'($urandom_range(0, 3));
            s.urs   = 1'($urandom_range(0, 1));
            s.urt   = 1'($urandom_range(0, 1));
            s.md    = ($urandom_range(0, 3) == 0);
            s.mf    = ($urandom_range(0, 4) == 0);
            s.mem2r = 1'($urandom_range(0, 1));
            s.regw  = 1'($urandom_range(0, 1));
            s.br    = ($urandom_range(0, 9) == 0);
            s.jmp   = ($urandom_range(0, 12) == 0);
            step(s, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS core. It decides each cycle whether the PC and IF/ID register advance and whether the IF/ID and ID/EX registers are cleared. It covers load-use stalls, branch/jump redirect flushes, and issue/occupancy tracking of the multi-cycle mult/div unit (HI/LO). It sits beside the ID stage. Its inputs come from the decoder and from the ID/EX register outputs; its outputs drive the PC enable, the IF/ID enable and flush, the ID/EX flush, and the mult/div unit start.

Parameters:
MULDIV_CYCLES, 32, mult/div latency in cycles; must be >= 1
CNT_W, 6, counter width; must satisfy 2^CNT_W > MULDIV_CYCLES

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
IdRs  in  5  rs field of the instruction in ID
IdRt  in  5  rt field of the instruction in ID
IdUseRs  in  1  ID instruction reads rs
IdUseRt  in  1  ID instruction reads rt
IdMulDiv  in  1  ID instruction is mult/multu/div/divu
IdMfHiLo  in  1  ID instruction is mfhi/mflo/mthi/mtlo
ExDst  in  5  destination register of the instruction in EX (ID/EX output)
ExMem2R  in  1  EX instruction is a load
ExRegW  in  1  EX instruction writes the register file
ExBranchTaken  in  1  branch resolved taken in EX
ExJump  in  1  jump resolved in EX
PcWrite  out  1  PC load enable
IfIdWrite  out  1  IF/ID load enable
IfIdFlush  out  1  clear IF/ID on the next edge
IdExFlush  out  1  insert a bubble into ID/EX on the next edge
MdStart  out  1  one-cycle start pulse to the mult/div unit
MdBusy  out  1  mult/div unit is occupied

Behaviour:
- State: FSM {RUN, MDBUSY} and a down-counter cnt[CNT_W-1:0].
- rst=1 at the edge: state becomes RUN, cnt becomes 0.
- While rst=1, outputs are forced to PcWrite=0, IfIdWrite=0, IfIdFlush=1, IdExFlush=1, MdStart=0, MdBusy=0.
- Outputs are combinational from the current state and inputs. There is no added latency.
- Decisions are evaluated in the priority order below.
- Redirect (highest priority):
  - Condition: ExBranchTaken|ExJump.
  - Outputs: PcWrite=1, IfIdWrite=1, IfIdFlush=1, IdExFlush=1, MdStart=0.
  - This overrides every stall. The ID instruction is wrong-path and is killed.
- Load-use:
  - Condition: ExMem2R & ExRegW & ExDst!=0 & ((IdUseRs & IdRs==ExDst) | (IdUseRt & IdRt==ExDst)).
  - Outputs: PcWrite=0, IfIdWrite=0, IfIdFlush=0, IdExFlush=1, MdStart=0.
  - The stall lasts exactly one cycle, because the load then leaves EX.
  - Register $0 never causes a stall.
- HI/LO structural stall:
  - Condition: state=MDBUSY & (IdMulDiv|IdMfHiLo).
  - Outputs: same as load-use.
  - The stall is held until the unit frees.
- Issue:
  - Condition: state=RUN & IdMulDiv & no redirect & no load-use.
  - Outputs: MdStart=1 for this cycle, plus the normal-advance values.
  - Next state: MDBUSY with cnt=MULDIV_CYCLES-1.
- Normal advance: PcWrite=1, IfIdWrite=1, IfIdFlush=0, IdExFlush=0, MdStart=0.
- MDBUSY state:
  - MdBusy=1.
  - When cnt!=0, cnt decrements each cycle.
  - When cnt==0, the next state is RUN.
  - MdBusy therefore stays high for exactly MULDIV_CYCLES cycles after the MdStart cycle.
  - A mult/div that was stalled in ID issues in the first RUN cycle. Back-to-back operations are separated by MULDIV_CYCLES cycles of busy.
- A redirect while in MDBUSY flushes the front end, but the counter keeps running, because the issued mult/div is older than the branch.
- MULDIV_CYCLES=1: MDBUSY lasts a single cycle.
- Simultaneous load-use and HI/LO stall give identical outputs, with no double counting.
- A reset mid-operation abandons MDBUSY immediately.
- The controller never asserts PcWrite=1 together with IfIdWrite=0.

Test Plan:
1. Load-use: EX holds lw with ExDst=8, ExMem2R=1, ExRegW=1; ID has IdRs=8, IdUseRs=1 -> exactly one cycle with PcWrite=0, IfIdWrite=0, IdExFlush=1. Next cycle, with ExMem2R=0, outputs return to normal advance.
2. $0 and unused-operand cases: ExDst=0 with IdRs=0 -> no stall. ExDst=9 with IdRt=9 and IdUseRt=0 -> no stall.
3. Redirect priority: ExBranchTaken=1 in the same cycle as a load-use match -> PcWrite=1, IfIdFlush=1, IdExFlush=1.
4. Mult/div with MULDIV_CYCLES=4:
   - IdMulDiv=1 in RUN -> MdStart pulses for 1 cycle, then MdBusy is high for 4 cycles.
   - IdMfHiLo=1 held from the MdStart cycle onward -> stalled for 4 cycles, advancing on cycle 5.
   - An independent add in ID during busy -> no stall.
5. Redirect and reset during busy:
   - ExJump at busy cycle 2 -> flush outputs, and MdBusy still ends on schedule.
   - rst at busy cycle 2 -> MdBusy=0 on the next cycle and state is RUN.
6. Back-to-back: two mult instructions in consecutive ID slots -> the second is stalled and issues MdStart exactly MULDIV_CYCLES+1 cycles after the first MdStart.
